// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the EX/MEM stage: sizes, aligns and issues
// one bus transaction per load/store, with timeout and misalignment handling.
module mem_access_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int TIMEOUT_CYC  = 15,
    parameter int MISALIGN_EXC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    output logic              stall_o,
    output logic [31:0]       load_data_o,
    output logic              load_valid_o,
    output logic              misalign_exc_o,
    output logic              bus_err_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-3:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t             state_q, state_d;
    size_t              size_d, size_q;
    logic               uns_q, we_q;
    logic [ADDR_W-1:0]  addr_al, addr_q;
    logic [3:0]         be_d, be_q;
    logic [31:0]        wdata_d, wdata_q, load_data_q, load_ext;
    logic [CNT_W-1:0]   cnt_q;
    logic               access, misaligned, mis_exc, timeout;
    logic               flag_load_q, flag_mis_q, flag_err_q;
    logic [31:0]        rd_shift;

    assign access     = valid_i && (mem_read_i || mem_write_i);
    assign misaligned = (size_d == SZ_H && addr_i[0]) || (size_d == SZ_W && addr_i[1:0] != 2'b00);
    assign mis_exc    = misaligned && (MISALIGN_EXC != 0);
    assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Request decode; reserved funct3 encodings fall through to word size
    always_comb begin
        size_d  = SZ_W;
        addr_al = addr_i;
        be_d    = 4'b1111;
        wdata_d = 32'h0;
        case (funct3_i[1:0])
            2'b00:   size_d = SZ_B;
            2'b01:   size_d = SZ_H;
            default: size_d = SZ_W;
        endcase
        if (size_d == SZ_H) addr_al[0] = 1'b0;
        if (size_d == SZ_W) addr_al[1:0] = 2'b00;
        if (mem_write_i) begin
            case (size_d)
                SZ_B: begin
                    be_d    = 4'b0001 << addr_al[1:0];
                    wdata_d = {4{store_data_i[7:0]}};
                end
                SZ_H: begin
                    be_d    = 4'b0011 << {addr_al[1], 1'b0};
                    wdata_d = {2{store_data_i[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = store_data_i;
                end
            endcase
        end
    end

    // Lane select and extension of the returned word
    always_comb begin
        rd_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_B:    load_ext = uns_q ? {24'h0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_H:    load_ext = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: if (access) begin
                stall_o = 1'b1;
                state_d = mis_exc ? RESP : REQ;
            end
            REQ: begin
                stall_o = 1'b1;
                if (dmem_ack_i || timeout) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= SZ_W;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            load_data_q <= 32'h0;
            cnt_q       <= '0;
            flag_load_q <= 1'b0;
            flag_mis_q  <= 1'b0;
            flag_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (access) begin
                    size_q      <= size_d;
                    uns_q       <= funct3_i[2] && (size_d != SZ_W);
                    we_q        <= mem_write_i;
                    addr_q      <= addr_al;
                    be_q        <= be_d;
                    wdata_q     <= wdata_d;
                    cnt_q       <= '0;
                    flag_load_q <= 1'b0;
                    flag_mis_q  <= mis_exc;
                    flag_err_q  <= 1'b0;
                end
                REQ: begin
                    if (dmem_ack_i) begin
                        if (!we_q) load_data_q <= load_ext;
                        flag_load_q <= !we_q;
                    end else if (timeout) begin
                        flag_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus fields are only driven while the request is live so reset clears them at once
    assign dmem_req_o     = (state_q == REQ);
    assign dmem_we_o      = dmem_req_o && we_q;
    assign dmem_addr_o    = dmem_req_o ? addr_q[ADDR_W-1:2] : '0;
    assign dmem_be_o      = dmem_req_o ? be_q : 4'h0;
    assign dmem_wdata_o   = dmem_req_o ? wdata_q : 32'h0;
    assign load_data_o    = load_data_q;
    assign load_valid_o   = (state_q == RESP) && flag_load_q;
    assign misalign_exc_o = (state_q == RESP) && flag_mis_q;
    assign bus_err_o      = (state_q == RESP) && flag_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: driver pushes expected events, monitor
// pops and compares whenever the DUT raises a request, load, exception or error.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic [2:0]        funct3_i = 3'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [31:0]       store_data_i = 32'h0;
    logic              stall_o, load_valid_o, misalign_exc_o, bus_err_o;
    logic [31:0]       load_data_o;
    logic              dmem_req_o, dmem_we_o;
    logic [ADDR_W-3:0] dmem_addr_o;
    logic [3:0]        dmem_be_o;
    logic [31:0]       dmem_wdata_o;
    logic [31:0]       dmem_rdata_i = 32'h0;
    logic              dmem_ack_i = 1'b0;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(15), .MISALIGN_EXC(1)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .stall_o(stall_o), .load_data_o(load_data_o),
        .load_valid_o(load_valid_o), .misalign_exc_o(misalign_exc_o), .bus_err_o(bus_err_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_ack_i(dmem_ack_i)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_REQ, EV_LOAD, EV_MIS, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [29:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endfunction

    function automatic void push(input ev_kind_t k, input logic [29:0] a, input logic we,
                                 input logic [3:0] be, input logic [31:0] wd, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void pop_check(input ev_kind_t seen);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", seen);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != seen) begin
            errors++;
            $display("FAIL event_kind: got %0d expected %0d", seen, e.kind);
            return;
        end
        case (seen)
            EV_REQ: begin
                chk("req_addr", 32'(dmem_addr_o), 32'(e.addr));
                chk("req_we", 32'(dmem_we_o), 32'(e.we));
                chk("req_be", 32'(dmem_be_o), 32'(e.be));
                chk("req_wdata", dmem_wdata_o, e.wdata);
            end
            EV_LOAD: chk("load_data", load_data_o, e.data);
            default: ;
        endcase
    endfunction

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        logic        req_prev;
        logic [29:0] a_h;
        logic [3:0]  be_h;
        logic [31:0] wd_h;
        logic        we_h;
        req_prev = 1'b0; a_h = '0; be_h = '0; wd_h = '0; we_h = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 1'b0;
            end else begin
                if (dmem_req_o && !req_prev) begin
                    pop_check(EV_REQ);
                    a_h = dmem_addr_o; be_h = dmem_be_o; wd_h = dmem_wdata_o; we_h = dmem_we_o;
                end else if (dmem_req_o) begin
                    chk("bus_stable", {dmem_addr_o, dmem_be_o, dmem_we_o} , {a_h, be_h, we_h});
                    chk("wdata_stable", dmem_wdata_o, wd_h);
                end
                if (load_valid_o)   pop_check(EV_LOAD);
                if (misalign_exc_o) pop_check(EV_MIS);
                if (bus_err_o)      pop_check(EV_ERR);
                if (misalign_exc_o && bus_err_o) chk("mis_and_err", 32'd1, 32'd0);
                req_prev = dmem_req_o;
            end
        end
    end

    // Starts and ends on a falling edge; ack_at = which request cycle acks (0 = never)
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int ack_at,
                          input logic [31:0] rdat, input int exp_stall, input string name);
        int stall_cyc, req_cyc;
        bit done;
        stall_cyc = 0; req_cyc = 0; done = 0;
        valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
        addr_i = a; store_data_i = sd; dmem_rdata_i = rdat;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (dmem_req_o) begin
                req_cyc++;
                dmem_ack_i = (ack_at > 0 && req_cyc == ack_at);
            end else begin
                dmem_ack_i = 1'b0;
            end
            if (!stall_o) done = 1;
            else begin
                stall_cyc++;
                @(negedge clk);
            end
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
        chk({name, "_stall"}, 32'(stall_cyc), 32'(exp_stall));
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; dmem_ack_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {26'h0, stall_o, load_valid_o, misalign_exc_o, bus_err_o, dmem_req_o, dmem_we_o}, 32'h0);
        chk("rst_addr", 32'(dmem_addr_o), 32'h0);
        chk("rst_be_wdata", dmem_wdata_o | 32'(dmem_be_o), 32'h0);
        chk("rst_load_data", load_data_o, 32'h0);
        rst_n = 1'b1;

        // LW 0x100, ack on third request cycle
        push(EV_REQ, 30'h40, 1'b0, 4'b1111, 32'h0, 32'h0);
        push(EV_LOAD, 30'h0, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF);
        access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4, "lw");

        // LB / LBU 0x103
        push(EV_REQ, 30'h40, 1'b0, 4'b1111, 32'h0, 32'h0);
        push(EV_LOAD, 30'h0, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80);
        access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80000000, 2, "lb");
        push(EV_REQ, 30'h40, 1'b0, 4'b1111, 32'h0, 32'h0);
        push(EV_LOAD, 30'h0, 1'b0, 4'h0, 32'h0, 32'h00000080);
        access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80000000, 2, "lbu");

        // LH / LHU 0x006 (upper halfword), LB 0x101
        push(EV_REQ, 30'h1, 1'b0, 4'b1111, 32'h0, 32'h0);
        push(EV_LOAD, 30'h0, 1'b0, 4'h0, 32'h0, 32'hFFFF8001);
        access(1, 0, 3'b001, 32'h006, 32'h0, 2, 32'h80011234, 3, "lh");
        push(EV_REQ, 30'h1, 1'b0, 4'b1111, 32'h0, 32'h0);
        push(EV_LOAD, 30'h0, 1'b0, 4'h0, 32'h0, 32'h00008001);
        access(1, 0, 3'b101, 32'h006, 32'h0, 1, 32'h80011234, 2, "lhu");
        push(EV_REQ, 30'h40, 1'b0, 4'b1111, 32'h0, 32'h0);
        push(EV_LOAD, 30'h0, 1'b0, 4'h0, 32'h0, 32'h00000056);
        access(1, 0, 3'b000, 32'h101, 32'h0, 1, 32'h12345678, 2, "lb1");

        // Stores
        push(EV_REQ, 30'h80, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0);
        access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0, 2, "sh");
        push(EV_REQ, 30'h0, 1'b1, 4'b1000, 32'h44444444, 32'h0);
        access(0, 1, 3'b000, 32'h003, 32'h11223344, 1, 32'h0, 2, "sb");
        push(EV_REQ, 30'hFF, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0);
        access(0, 1, 3'b010, 32'h3FC, 32'hCAFEF00D, 2, 32'h0, 3, "sw");

        // Reserved funct3 treated as word
        push(EV_REQ, 30'h2, 1'b0, 4'b1111, 32'h0, 32'h0);
        push(EV_LOAD, 30'h0, 1'b0, 4'h0, 32'h0, 32'h0BADF00D);
        access(1, 0, 3'b011, 32'h008, 32'h0, 1, 32'h0BADF00D, 2, "f3_rsvd");

        // Misaligned accesses: no bus request, one-cycle stall
        push(EV_MIS, 30'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        access(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1, "lw_mis");
        push(EV_MIS, 30'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        access(0, 1, 3'b001, 32'h201, 32'h5555, 1, 32'h0, 1, "sh_mis");
        push(EV_MIS, 30'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        access(1, 0, 3'b011, 32'h009, 32'h0, 1, 32'h0, 1, "rsvd_mis");

        // Timeout, then a late ack in IDLE must be ignored
        push(EV_REQ, 30'hC0, 1'b0, 4'b1111, 32'h0, 32'h0);
        push(EV_ERR, 30'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        access(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h11111111, 16, "timeout");
        dmem_ack_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_idle", {30'h0, dmem_req_o, load_valid_o}, 32'h0);
        end
        dmem_ack_i = 1'b0;

        // Reset mid-request drops dmem_req_o without a clock edge
        push(EV_REQ, 30'h4, 1'b1, 4'b1111, 32'h87654321, 32'h0);
        valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h10; store_data_i = 32'h87654321;
        @(negedge clk);
        valid_i = 1'b0; mem_write_i = 1'b0;
        #1 chk("req_before_rst", 32'(dmem_req_o), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("req_async_rst", {29'h0, dmem_req_o, dmem_we_o, stall_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push(EV_REQ, 30'h1, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0);
        access(0, 1, 3'b000, 32'h005, 32'h000000A5, 1, 32'h0, 2, "sb_after_rst");

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
